// File: rtl/mdu_pkg.sv
// Shared MDU definitions: op codes, FSM state encoding and default latencies.
// MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops.
package mdu_pkg;

    localparam int DATA_W          = 32;
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic [3:0] {
        OP_MULT  = 4'd0,
        OP_MULTU = 4'd1,
        OP_DIV   = 4'd2,
        OP_DIVU  = 4'd3,
        OP_MFHI  = 4'd4,
        OP_MFLO  = 4'd5,
        OP_MTHI  = 4'd6,
        OP_MTLO  = 4'd7,
        OP_MADD  = 4'd8,
        OP_MADDU = 4'd9,
        OP_MSUB  = 4'd10,
        OP_MSUBU = 4'd11
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    // Ops that occupy the unit for a multi-cycle latency and write HI/LO at the end.
    function automatic logic is_arith(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
                          OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
`else
        return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
`endif
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return op inside {OP_DIV, OP_DIVU};
    endfunction

    function automatic logic is_signed_op(input logic [3:0] op);
        return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
    endfunction

endpackage

// File: rtl/mdu_if.sv
// Issue/result interface between the decode stage (master) and the MDU (slave).
interface mdu_if;
    import mdu_pkg::*;

    logic              start;
    logic [3:0]        op;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic              busy;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic [DATA_W-1:0] rd_val;

    modport master (
        output start, op, rs_val, rt_val,
        input  busy, hi, lo, rd_val
    );

    modport slave (
        input  start, op, rs_val, rt_val,
        output busy, hi, lo, rd_val
    );

endinterface

// File: rtl/mdu_arith.sv
// Combinational 64-bit multiply/divide datapath on the latched operands.
// MDU_MADD_EN adds the HI/LO accumulate path for MADD/MSUB-class ops.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]          op,
    input  logic [DATA_W-1:0]   rs,
    input  logic [DATA_W-1:0]   rt,
`ifdef MDU_MADD_EN
    input  logic [2*DATA_W-1:0] acc,
`endif
    output logic [DATA_W-1:0]   hi_nxt,
    output logic [DATA_W-1:0]   lo_nxt,
    output logic                wr_en
);

    logic                       sgn;
    logic                       neg_a;
    logic                       neg_b;
    logic signed [2*DATA_W-1:0] a_x;
    logic signed [2*DATA_W-1:0] b_x;
    logic signed [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]          a_mag;
    logic [DATA_W-1:0]          b_mag;
    logic [DATA_W-1:0]          b_safe;
    logic [DATA_W-1:0]          q_mag;
    logic [DATA_W-1:0]          r_mag;
    logic [DATA_W-1:0]          quo;
    logic [DATA_W-1:0]          rem;
    logic [2*DATA_W-1:0]        res;

    always_comb begin
        sgn   = is_signed_op(op);
        // One multiplier serves both signednesses: extension choice sets the product.
        a_x   = {{DATA_W{sgn & rs[DATA_W-1]}}, rs};
        b_x   = {{DATA_W{sgn & rt[DATA_W-1]}}, rt};
        prod  = a_x * b_x;

        // Divide on magnitudes so 0x80000000 / -1 cannot overflow the divider.
        neg_a  = sgn & rs[DATA_W-1];
        neg_b  = sgn & rt[DATA_W-1];
        a_mag  = neg_a ? -rs : rs;
        b_mag  = neg_b ? -rt : rt;
        b_safe = (b_mag == '0) ? DATA_W'(1) : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        quo    = (neg_a ^ neg_b) ? -q_mag : q_mag;
        rem    = neg_a ? -r_mag : r_mag;

        res   = $unsigned(prod);
        wr_en = 1'b1;
        case (op)
            OP_DIV, OP_DIVU: begin
                res   = {rem, quo};
                wr_en = (rt != '0);
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: res = acc + $unsigned(prod);
            OP_MSUB, OP_MSUBU: res = acc - $unsigned(prod);
`endif
            default: ;
        endcase

        hi_nxt = res[2*DATA_W-1:DATA_W];
        lo_nxt = res[DATA_W-1:0];
    end

endmodule

// File: rtl/mdu.sv
// MDU top: IDLE/BUSY control, latency counter, operand latches and HI/LO.
// MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input logic  clk,
    input logic  reset_n,
    mdu_if.slave bus
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    mdu_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic [3:0]        op_p0;
    logic [DATA_W-1:0] rs_p0;
    logic [DATA_W-1:0] rt_p0;
    logic [DATA_W-1:0] hi_r;
    logic [DATA_W-1:0] lo_r;
    logic [DATA_W-1:0] hi_nxt;
    logic [DATA_W-1:0] lo_nxt;
    logic              wr_en;

    mdu_arith u_arith (
        .op     (op_p0),
        .rs     (rs_p0),
        .rt     (rt_p0),
`ifdef MDU_MADD_EN
        .acc    ({hi_r, lo_r}),
`endif
        .hi_nxt (hi_nxt),
        .lo_nxt (lo_nxt),
        .wr_en  (wr_en)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            op_p0 <= '0;
            rs_p0 <= '0;
            rt_p0 <= '0;
            hi_r  <= '0;
            lo_r  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (is_arith(bus.op)) begin
                            op_p0 <= bus.op;
                            rs_p0 <= bus.rs_val;
                            rt_p0 <= bus.rt_val;
                            cnt   <= is_div(bus.op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                            state <= ST_BUSY;
                        end else if (bus.op == OP_MTHI) begin
                            hi_r <= bus.rs_val;
                        end else if (bus.op == OP_MTLO) begin
                            lo_r <= bus.rs_val;
                        end
                    end
                end
                // Operand stage p0 is consumed only on the final busy cycle.
                ST_BUSY: begin
                    if (cnt == CNT_W'(1)) begin
                        if (wr_en) begin
                            hi_r <= hi_nxt;
                            lo_r <= lo_nxt;
                        end
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy   = (state == ST_BUSY);
    assign bus.hi     = hi_r;
    assign bus.lo     = lo_r;
    assign bus.rd_val = (bus.op == OP_MFHI) ? hi_r :
                        (bus.op == OP_MFLO) ? lo_r : '0;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed corner cases plus random ops against a model.
// Expectations for ops 8-11 follow MDU_MADD_EN.
module tb_mdu;

    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    mdu_if bus ();

    mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural model: plain 64-bit arithmetic on the HI/LO pair.
    task automatic model(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         output int cyc);
        longint      sa, sb, q, r;
        logic [63:0] p, acc;
        sa  = longint'($signed(rs));
        sb  = longint'($signed(rt));
        acc = {hi_m, lo_m};
        cyc = 0;
        case (op)
            4'd0: begin p = sa * sb; {hi_m, lo_m} = p; cyc = MC; end
            4'd1: begin p = {32'b0, rs} * {32'b0, rt}; {hi_m, lo_m} = p; cyc = MC; end
            4'd2: begin
                if (rt != 0) begin
                    q = sa / sb; r = sa % sb;
                    lo_m = q[31:0]; hi_m = r[31:0];
                end
                cyc = DC;
            end
            4'd3: begin
                if (rt != 0) begin lo_m = rs / rt; hi_m = rs % rt; end
                cyc = DC;
            end
            4'd6: hi_m = rs;
            4'd7: lo_m = rs;
`ifdef MDU_MADD_EN
            4'd8:  begin p = sa * sb; {hi_m, lo_m} = acc + p; cyc = MC; end
            4'd9:  begin p = {32'b0, rs} * {32'b0, rt}; {hi_m, lo_m} = acc + p; cyc = MC; end
            4'd10: begin p = sa * sb; {hi_m, lo_m} = acc - p; cyc = MC; end
            4'd11: begin p = {32'b0, rs} * {32'b0, rt}; {hi_m, lo_m} = acc - p; cyc = MC; end
`endif
            default: ;
        endcase
    endtask

    // Called at posedge+1; returns at posedge+1 once the op has completed.
    task automatic run_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input bit inject);
        logic [31:0] exp_rd, hi0, lo0;
        int          exp_cyc, n;
        bit          hold_ok;
        exp_rd = (op == 4'd4) ? hi_m : (op == 4'd5) ? lo_m : 32'd0;
        hi0 = hi_m;
        lo0 = lo_m;
        model(op, rs, rt, exp_cyc);
        bus.start = 1'b1; bus.op = op; bus.rs_val = rs; bus.rt_val = rt;
        #1;
        check("rd_val", bus.rd_val, exp_rd);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op = 4'd0;
        n = 0;
        hold_ok = 1'b1;
        while (bus.busy && n < 50) begin
            if (bus.hi !== hi0 || bus.lo !== lo0) hold_ok = 1'b0;
            if (inject && n == 1) begin
                bus.start = 1'b1; bus.op = 4'd7; bus.rs_val = 32'hAA;
            end else begin
                bus.start = 1'b0; bus.op = 4'd0;
            end
            @(posedge clk); #1;
            n++;
        end
        bus.start = 1'b0; bus.op = 4'd0;
        check("busy_cycles", 32'(n), 32'(exp_cyc));
        check("hold_in_busy", 32'(hold_ok), 32'd1);
        check("hi", bus.hi, hi_m);
        check("lo", bus.lo, lo_m);
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] rrs, rrt;
        int          sel;

        bus.start = 1'b0; bus.op = 4'd0; bus.rs_val = '0; bus.rt_val = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_hi", bus.hi, 32'd0);
        check("reset_lo", bus.lo, 32'd0);
        check("reset_rd", bus.rd_val, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        run_op(4'd0, 32'hFFFFFFFF, 32'd2, 1'b0);
        check("mult_hi", bus.hi, 32'hFFFFFFFF);
        check("mult_lo", bus.lo, 32'hFFFFFFFE);
        run_op(4'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
        check("multu_hi", bus.hi, 32'h00000001);
        check("multu_lo", bus.lo, 32'hFFFFFFFE);

        run_op(4'd2, -32'sd7, 32'd2, 1'b0);
        check("div_lo", bus.lo, 32'hFFFFFFFD);
        check("div_hi", bus.hi, 32'hFFFFFFFF);
        run_op(4'd3, 32'd7, 32'd0, 1'b0);
        check("divu0_lo", bus.lo, 32'hFFFFFFFD);
        check("divu0_hi", bus.hi, 32'hFFFFFFFF);
        run_op(4'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        check("divovf_lo", bus.lo, 32'h80000000);
        check("divovf_hi", bus.hi, 32'd0);

        run_op(4'd6, 32'h1234, 32'd0, 1'b0);
        run_op(4'd7, 32'h5678, 32'd0, 1'b0);
        run_op(4'd4, 32'd0, 32'd0, 1'b0);
        check("mthi_hi", bus.hi, 32'h1234);
        run_op(4'd5, 32'd0, 32'd0, 1'b0);
        for (int k = 12; k < 16; k++) run_op(4'(k), 32'hDEAD, 32'hBEEF, 1'b0);

        run_op(4'd0, 32'd3, 32'd4, 1'b1);
        check("inject_lo", bus.lo, 32'd12);
        check("inject_hi", bus.hi, 32'd0);

        // Abort a DIV at its third busy cycle.
        bus.start = 1'b1; bus.op = 4'd2; bus.rs_val = 32'd100; bus.rt_val = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op = 4'd0;
        repeat (2) begin @(posedge clk); #1; end
        check("pre_abort_busy", 32'(bus.busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_hi", bus.hi, 32'd0);
        check("abort_lo", bus.lo, 32'd0);
        hi_m = '0; lo_m = '0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        run_op(4'd0, 32'd2, 32'd3, 1'b0);
        check("post_reset_lo", bus.lo, 32'd6);

        run_op(4'd6, 32'd0, 32'd0, 1'b0);
        run_op(4'd7, 32'd10, 32'd0, 1'b0);
        run_op(4'd8, 32'd3, 32'd4, 1'b0);
`ifdef MDU_MADD_EN
        check("madd_lo", bus.lo, 32'd22);
`else
        check("madd_lo", bus.lo, 32'd10);
`endif

        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom_range(0, 15));
            rrs = $urandom;
            rrt = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rrt = 32'd0;
            if (sel == 1) rrt = 32'($urandom_range(1, 9));
            if (sel == 2) begin rrs = 32'h80000000; rrt = 32'hFFFFFFFF; end
            if (sel == 3) rrs = 32'($urandom_range(0, 100));
            run_op(rop, rrs, rrt, (sel == 4));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy-cycle count for MULT/MULTU/MADD-class ops.
REQ-002 Parameter DIV_CYCLES, default 10, busy-cycle count for DIV/DIVU.
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  op valid this cycle; issued only for instructions classed multdiv by the decode stage.
REQ-006 op  input  4  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MFHI, 5 MFLO, 6 MTHI, 7 MTLO, 8 MADD, 9 MADDU, 10 MSUB, 11 MSUBU; 12-15 reserved.
REQ-007 rs_val  input  32  forwarded rs operand.
REQ-008 rt_val  input  32  forwarded rt operand.
REQ-009 busy  output  1  arithmetic op in flight.
REQ-010 hi  output  32  HI register.
REQ-011 lo  output  32  LO register.
REQ-012 rd_val  output  32  MFHI/MFLO result.

Function
REQ-013 Shall implement a two-state FSM: IDLE, BUSY.
REQ-014 IDLE + start + arithmetic op: latch rs_val, rt_val, op; go to BUSY; load counter with MULT_CYCLES or DIV_CYCLES.
REQ-015 busy shall be 1 from the cycle after acceptance through the last BUSY cycle (exactly N cycles), combinational from state.
REQ-016 In BUSY the counter decrements each cycle; at count 1, hi/lo update at that edge and FSM returns to IDLE.
REQ-017 hi/lo shall hold old values throughout BUSY; no partial results visible.
REQ-018 start while BUSY shall be ignored entirely; the stall logic guarantees it never occurs, and the bench checks that it has no effect.
REQ-019 MTHI/MTLO in IDLE: hi or lo takes rs_val at the next edge; busy stays 0.
REQ-020 MFHI/MFLO: rd_val = hi or lo combinationally, no state change; rd_val = 0 for all other ops.
REQ-021 MULT/MADD/MSUB signed 64-bit product; MULTU/MADDU/MSUBU unsigned; {hi,lo} = product, {hi,lo}+product, or {hi,lo}-product, mod 2^64.
REQ-022 DIV signed, truncating toward zero, remainder takes the dividend's sign; lo = quotient, hi = remainder; DIVU unsigned.
REQ-023 Divisor 0 shall leave hi/lo unchanged, though busy still runs DIV_CYCLES.
REQ-024 DIV 0x80000000 / 0xFFFFFFFF shall give lo = 0x80000000, hi = 0.
REQ-025 Reserved op codes shall be no-ops, with no busy and no hi/lo change.

Reset
REQ-026 Asserting reset_n low shall immediately set state IDLE, counter 0, busy 0, hi 0, lo 0, and latched operands 0.
REQ-027 Reset during BUSY shall abort the op with no hi/lo update; first start is accepted on the first rising edge after deassertion.

Configuration
REQ-028 Macro MDU_MADD_EN defined: ops 8-11 behave per REQ-021 with MULT_CYCLES latency.
REQ-029 MDU_MADD_EN undefined: ops 8-11 shall be treated as reserved per REQ-025, and no accumulate logic is synthesized.

Structure
REQ-030 Op codes, state encoding and default cycle counts shall reside in shared package mdu_pkg, which the decode stage also uses.
REQ-031 The 64-bit multiply and divide datapath shall be one sub-module mdu_arith, which is combinational on the latched operands; the FSM, counter and HI/LO stay in mdu.

Verification
REQ-032 MULT 0xFFFFFFFF x 2 -> busy for 5 cycles, then hi = 0xFFFFFFFF, lo = 0xFFFFFFFE; MULTU same operands -> hi = 0x00000001, lo = 0xFFFFFFFE.
REQ-033 DIV -7 / 2 -> after 10 busy cycles, lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; DIVU 7 / 0 -> hi/lo unchanged, busy still 10 cycles.
REQ-034 MTHI 0x1234, MTLO 0x5678 on consecutive cycles, then MFHI -> busy never set; rd_val = 0x1234.
REQ-035 Second start (MTLO 0xAA) issued mid-BUSY of MULT 3x4 -> ignored; lo = 12, hi = 0.
REQ-036 reset_n pulsed low at busy cycle 3 of DIV -> busy 0 and hi = lo = 0 immediately; a new MULT 2x3 is accepted after release and gives lo = 6.
REQ-037 With MDU_MADD_EN: hi/lo = 0/10, MADD 3x4 -> lo = 22; without MDU_MADD_EN, the same stimulus -> lo = 10, busy 0.
